genesis_pad_scanner: RTL

//  Scans NUM_PADS Sega-style 3/6-button controllers sharing one select line.

---
 rtl/genesis_pad_scanner.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/genesis_pad_scanner.sv
// rtl/genesis_pad_scanner.sv - frame-timed select burst scanner for Sega 3/6-button pads
// Decodes, auto-detects and debounces NUM_PADS pads sharing one select line; emits an action code per pad.
module genesis_pad_scanner #(
    parameter int NUM_PADS        = 1,
    parameter int SEL_HALF_CYCLES = 250,
    parameter int FRAME_CYCLES    = 400000,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [6*NUM_PADS-1:0]  d_in,
    output logic                   sel,
    output logic [12*NUM_PADS-1:0] buttons,
    output logic [NUM_PADS-1:0]    six_btn,
    output logic [NUM_PADS-1:0]    connected,
    output logic [3*NUM_PADS-1:0]  action,
    output logic                   valid
);

    localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int PW = (SEL_HALF_CYCLES > 1) ? $clog2(SEL_HALF_CYCLES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
    localparam logic [PW-1:0] PH_LAST    = PW'(SEL_HALF_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_P1, S_P2, S_P3, S_P4, S_P5, S_P6, S_P7, S_P8
    } state_t;

    state_t                     state;
    logic [FW-1:0]              frame_cnt;
    logic [PW-1:0]              ph_cnt;
    logic [6*NUM_PADS-1:0]      sync1;
    logic [6*NUM_PADS-1:0]      sync2;
    logic [11:0]                raw [NUM_PADS];
    logic [NUM_PADS-1:0]        conn_r;
    logic [NUM_PADS-1:0]        sixa;
    logic [NUM_PADS-1:0]        sixb;
    logic [DEBOUNCE_FRAMES-1:0] hist [NUM_PADS][12];

    logic [5:0]                 pad_d [NUM_PADS];
    logic [11:0]                raw_m [NUM_PADS];
    logic [DEBOUNCE_FRAMES-1:0] hist_n [NUM_PADS][12];
    logic [NUM_PADS-1:0]        six_c;
    logic [12*NUM_PADS-1:0]     btn_n;
    logic [3*NUM_PADS-1:0]      action_n;

    function automatic logic [2:0] pick_action(input logic [11:0] b, input logic present);
        if (!present) return 3'b111;
        if (b[7])     return 3'b100;
        if (b[0])     return 3'b000;
        if (b[1])     return 3'b001;
        if (b[3])     return 3'b010;
        if (b[2])     return 3'b011;
        return 3'b111;
    endfunction

    // Frame commit values: masked raw bits shifted into per-bit history; a bit moves only on a unanimous history.
    always_comb begin
        pad_d    = '{default: '0};
        raw_m    = '{default: '0};
        hist_n   = '{default: '0};
        six_c    = conn_r & sixa & sixb;
        btn_n    = buttons;
        action_n = '1;
        for (int p = 0; p < NUM_PADS; p++) begin
            pad_d[p] = sync2[6*p +: 6];
            raw_m[p] = raw[p];
            if (!six_c[p])
                raw_m[p][11:8] = 4'b0000;
            if (!conn_r[p])
                raw_m[p] = 12'h000;
            for (int b = 0; b < 12; b++) begin
                hist_n[p][b] = (hist[p][b] << 1) | DEBOUNCE_FRAMES'(raw_m[p][b]);
                if (&hist_n[p][b])
                    btn_n[12*p + b] = 1'b1;
                else if (!(|hist_n[p][b]))
                    btn_n[12*p + b] = 1'b0;
            end
            action_n[3*p +: 3] = pick_action(btn_n[12*p +: 12], conn_r[p]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            frame_cnt <= '0;
            ph_cnt    <= '0;
            sync1     <= '1;
            sync2     <= '1;
            sel       <= 1'b1;
            valid     <= 1'b0;
            buttons   <= '0;
            six_btn   <= '0;
            connected <= '0;
            action    <= '1;
            conn_r    <= '0;
            sixa      <= '0;
            sixb      <= '0;
            for (int p = 0; p < NUM_PADS; p++) begin
                raw[p] <= 12'h000;
                for (int b = 0; b < 12; b++)
                    hist[p][b] <= '0;
            end
        end else begin
            sync1     <= d_in;
            sync2     <= sync1;
            frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
            valid     <= 1'b0;
            if (state == S_IDLE) begin
                ph_cnt <= '0;
                if (frame_cnt == '0) begin
                    state <= S_P1;
                    sel   <= 1'b0;
                end
            end else if (ph_cnt != PH_LAST) begin
                ph_cnt <= ph_cnt + 1'b1;
            end else begin
                ph_cnt <= '0;
                for (int p = 0; p < NUM_PADS; p++) begin
                    case (state)
                        S_P1: begin
                            conn_r[p]  <= ~pad_d[p][2] & ~pad_d[p][3];
                            raw[p][4]  <= ~pad_d[p][4];
                            raw[p][7]  <= ~pad_d[p][5];
                        end
                        S_P2: begin
                            raw[p][3:0] <= ~pad_d[p][3:0];
                            raw[p][5]   <= ~pad_d[p][4];
                            raw[p][6]   <= ~pad_d[p][5];
                        end
                        S_P5: sixa[p] <= (pad_d[p][3:0] == 4'b0000);
                        S_P6: raw[p][11:8] <= ~pad_d[p][3:0];
                        S_P7: sixb[p] <= (pad_d[p][3:0] == 4'b1111);
                        default: ;
                    endcase
                end
                if (state == S_P8) begin
                    state     <= S_IDLE;
                    sel       <= 1'b1;
                    valid     <= 1'b1;
                    buttons   <= btn_n;
                    action    <= action_n;
                    six_btn   <= six_c;
                    connected <= conn_r;
                    hist      <= hist_n;
                end else begin
                    state <= state_t'(state + 4'd1);
                    sel   <= ~sel;
                end
            end
        end
    end

endmodule
